// File: rtl/seq_mult8_ctrl.sv
// Sequential 8x8 unsigned shift-and-add multiplier with valid/ready on both sides.
// One partial product per cycle goes through a single 8-bit Kogge-Stone prefix adder.

module ppa8 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;

    assign p0 = a ^ b;

    // Carry-in is structurally zero, so the prefix tree starts from plain generate/propagate.
    // Descending index order keeps reads of [i-d] on the previous level's values.
    always_comb begin
        g = a & b;
        p = p0;
        for (int d = 1; d < WIDTH; d = d * 2) begin
            for (int i = WIDTH - 1; i >= d; i--) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
    end

    always_comb begin
        sum    = p0;
        sum[0] = p0[0];
        for (int i = 1; i < WIDTH; i++)
            sum[i] = p0[i] ^ g[i-1];
        cout = g[WIDTH-1];
    end
endmodule

module seq_mult8_ctrl #(
    parameter int WIDTH      = 8,   // fixed by the 8-bit prefix adder
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               in_ready,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] out_prod,
    input  logic               out_ready
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [2:0]       cnt;

    logic             accept;
    logic             zero_op;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] s;
    logic             c;

    ppa8 #(.WIDTH(WIDTH)) u_ppa (
        .a    (hi),
        .b    (mcand),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign accept  = in_valid && in_ready;
    assign zero_op = EARLY_ZERO && ((in_a == '0) || (in_b == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_prod  = '0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = zero_op ? DONE : CALC;
            end
            CALC: begin
                if (cnt == 3'd7)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                out_prod  = {hi, lo};
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Add the multiplicand only when the current multiplier bit is set; carry is kept as bit 8.
    always_comb begin
        if (lo[0]) begin
            c = add_cout;
            s = add_sum;
        end else begin
            c = 1'b0;
            s = hi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                mcand <= in_a;
                hi    <= '0;
                lo    <= zero_op ? '0 : in_b;
                cnt   <= '0;
            end
        end else if (state == CALC) begin
            hi  <= {c, s[WIDTH-1:1]};
            lo  <= {s[0], lo[WIDTH-1:1]};
            cnt <= cnt + 3'd1;
        end
    end
endmodule

// File: tb/tb_seq_mult8_ctrl.sv
// Directed and random checks of seq_mult8_ctrl: product values, latency, back-pressure,
// mid-operation reset, and the no-skip zero-operand variant.

module tb_seq_mult8_ctrl;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_valid0;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_ready;
    logic        in_ready, in_ready0;
    logic        out_valid, out_valid0;
    logic [15:0] out_prod, out_prod0;

    int checks = 0;
    int errors = 0;

    seq_mult8_ctrl #(.WIDTH(8), .EARLY_ZERO(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_prod  (out_prod),
        .out_ready (out_ready)
    );

    seq_mult8_ctrl #(.WIDTH(8), .EARLY_ZERO(1'b0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid0),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ready  (in_ready0),
        .out_valid (out_valid0),
        .out_prod  (out_prod0),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transaction on the EARLY_ZERO=1 instance. in_valid stays high with scrambled
    // operands while busy; the block must ignore both.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                          input int exp_lat, input int hold);
        int n;
        @(negedge clk);
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        chk("idle_rdy", in_ready, 1);
        @(posedge clk);
        #1;
        n    = 1;
        in_a = ~a;
        in_b = ~b;
        chk("busy_rdy", in_ready, 0);
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("lat", n, exp_lat);
        chk("prod", out_prod, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_vld", out_valid, 1);
            chk("hold_prod", out_prod, exp);
            chk("hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("post_vld", out_valid, 0);
        chk("post_rdy", in_ready, 1);
        chk("post_prod", out_prod, 0);
    endtask

    initial begin
        int n;
        logic [7:0] ra, rb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_valid0 = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        out_ready = 1'b0;
        #12;
        chk("rst_rdy", in_ready, 1);
        chk("rst_vld", out_valid, 0);
        chk("rst_prod", out_prod, 0);
        chk("rst_rdy0", in_ready0, 1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'hFF, 8'hFF, 16'hFE01, 9, 0);
        run_op(8'h80, 8'h02, 16'h0100, 9, 0);
        run_op(8'h01, 8'h01, 16'h0001, 9, 0);
        run_op(8'h00, 8'h5A, 16'h0000, 1, 0);
        run_op(8'hA5, 8'h00, 16'h0000, 1, 0);
        run_op(8'h12, 8'h34, 16'h03A8, 9, 20);

        // No-skip variant: zero operand still takes the full 8 steps
        @(negedge clk);
        in_a      = 8'h00;
        in_b      = 8'h5A;
        in_valid0 = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        n = 1;
        while (!out_valid0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("lat0", n, 9);
        chk("prod0", out_prod0, 16'h0000);
        @(posedge clk);
        #1;
        chk("post_vld0", out_valid0, 0);

        // Abort at CALC step 4
        @(negedge clk);
        in_a      = 8'h37;
        in_b      = 8'h59;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_rdy", in_ready, 1);
        chk("abort_vld", out_valid, 0);
        chk("abort_prod", out_prod, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h0F, 8'h0F, 16'h00E1, 9, 0);

        for (int i = 0; i < 256; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i == 7)  ra = 8'h00;
            if (i == 13) rb = 8'h00;
            run_op(ra, rb, 16'(ra) * 16'(rb), (ra == 8'h00 || rb == 8'h00) ? 1 : 9, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
